bist_ctrl: RTL and testbench
============================

# bist_ctrl

Parametrised logic-BIST controller wrapped around a gate-level combinational or pipelined cone under test (CUT), such as the team's NAND/NOR/INV benchmark netlists. It generates pseudo-random input patterns from an LFSR and drives them into the CUT. It compacts the CUT responses in a MISR and compares the final signature against a golden value. It replaces hand-written per-netlist stimulus and sits between the test harness and any IN_W-input / OUT_W-output netlist instance.

## Interface
- IN_W, 3: CUT input width and LFSR width (≥2).
- OUT_W, 3: CUT output width and MISR width (≥2).
- LFSR_POLY, 3'b110: LFSR tap mask, IN_W bits.
- LFSR_SEED, 3'b001: LFSR reset/start value; must be non-zero.
- MISR_POLY, 3'b110: MISR tap mask, OUT_W bits.
- NUM_PAT, 7: patterns per run (≥1).
- CUT_LAT, 0: CUT pipeline latency in cycles (0..15).
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start_i, in, 1: begin a run; sampled in IDLE and DONE only.
- golden_i, in, OUT_W: expected signature; sampled on the final MISR update.
- resp_i, in, OUT_W: CUT response.
- pat_o, out, IN_W: current pattern (the LFSR register).
- pat_vld_o, out, 1: pat_o is a live pattern.
- busy_o, out, 1: run in progress (RUN or DRAIN).
- done_o, out, 1: one-cycle pulse when the signature is final.
- pass_o, out, 1: signature equals golden_i; held until next start.
- sig_o, out, OUT_W: MISR contents.

## Operation
- Reset values:
  - state = IDLE.
  - pat_o = LFSR_SEED.
  - sig_o = 0.
  - pat_vld_o, busy_o, done_o and pass_o = 0.
  - Pattern counter and capture delay line = 0.
- LFSR step: lfsr <= {lfsr[IN_W-2:0], ^(lfsr & LFSR_POLY)}.
- MISR step: misr <= {misr[OUT_W-2:0], ^(misr & MISR_POLY)} ^ resp_i.
- FSM states:
  - IDLE:
    - On start_i, go to RUN.
    - Reload LFSR to LFSR_SEED, clear MISR, clear pass_o.
  - RUN:
    - pat_vld_o = 1 and the LFSR steps every cycle.
    - Stay for exactly NUM_PAT cycles (counter 0..NUM_PAT-1).
    - Then go to DRAIN if CUT_LAT > 0, else to DONE.
  - DRAIN:
    - pat_vld_o = 0; LFSR holds.
    - Stay for exactly CUT_LAT cycles.
    - Then go to DONE.
  - DONE:
    - done_o = 1 for this single cycle.
    - pass_o <= (final misr == golden_i), registered on entry.
    - Go to IDLE, or to RUN directly if start_i = 1 (same reload as IDLE).
- Capture qualifier: pat_vld_o delayed by CUT_LAT flops (a wire when CUT_LAT = 0). The MISR updates only when the qualifier is 1, so it captures exactly NUM_PAT responses.
- start_i during RUN or DRAIN is ignored.
- rst_n low mid-run returns all state and outputs to reset values immediately. No partial signature survives.
- LFSR wraps naturally; NUM_PAT > 2^IN_W-1 repeats patterns, which is legal.

## Timing
- start_i is sampled at edge E0. RUN occupies the cycles after edges E0..E0+NUM_PAT-1.
- Pattern k (k = 0..NUM_PAT-1) is on pat_o in cycle k of RUN.
- Its response is sampled at the edge ending cycle k+CUT_LAT.
- done_o is high in the cycle after edge E0+NUM_PAT+CUT_LAT.
- Latency from start to done_o is NUM_PAT+CUT_LAT+1 cycles.
- sig_o and pass_o are valid from the done_o cycle and stable until the next start.
- busy_o = (state == RUN || state == DRAIN).

## Structure
- Shared package bist_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - a parity helper function;
  - a counter-width function clog2-based on max(NUM_PAT, CUT_LAT).
- The only sub-module is bist_shreg: a parametrised-width, parametrised-length linear shift register used for both LFSR and MISR. It has a mode input (autonomous or XOR-inject) and a load input.
- The capture delay line is inline.

## Test plan
- Defaults, resp_i tied to pat_o, golden_i = 3'b100, start pulse:
  - pat_o = 001, 010, 101, 011, 111, 110, 100 on consecutive cycles;
  - done_o 8 cycles after start;
  - sig_o = 3'b100, pass_o = 1.
- Same run with golden_i = 3'b000 -> sig_o = 3'b100, pass_o = 0.
- resp_i = 0, golden_i = 0 -> sig_o stays 0 throughout, pass_o = 1.
- CUT_LAT = 2, with resp_i driven by a 2-flop delay of pat_o:
  - DRAIN lasts 2 cycles;
  - done_o 10 cycles after start;
  - sig_o = 3'b100.
- start_i re-asserted mid-RUN -> ignored, run length unchanged. start_i held high through DONE -> RUN re-entered the next cycle with the LFSR reseeded to 001.
- rst_n pulsed low in RUN cycle 3 -> all outputs are at reset values in the same cycle, and the FSM stays IDLE until a new start.

Source files
------------

// File: rtl/bist_pkg.sv
// bist_pkg: shared types and helpers for the logic-BIST controller.
package bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  typedef enum logic {SR_AUTO, SR_INJ} sr_mode_e;
  function automatic logic parity(input logic [63:0] v);
    return ^v;
  endfunction
  function automatic int cnt_w(input int num_pat, input int cut_lat);
    int m;
    m = (num_pat > cut_lat) ? num_pat : cut_lat;
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/bist_shreg.sv
// bist_shreg: linear feedback shift register, autonomous (LFSR) or response-injecting (MISR).
module bist_shreg
  import bist_pkg::*;
#(
  parameter int W = 3,
  parameter logic [W-1:0] POLY = '1,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  sr_mode_e     mode,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);
  logic [W-1:0] fb;
  assign fb = {q[W-2:0], parity(64'(q & POLY))};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= INIT;
    else if (load) q <= load_val;
    else if (en) q <= (mode == SR_INJ) ? fb ^ din : fb;
endmodule

// File: rtl/bist_ctrl.sv
// bist_ctrl: LFSR pattern generator and MISR compactor around a cone under test,
// with run sequencing and golden-signature comparison.
module bist_ctrl
  import bist_pkg::*;
#(
  parameter int IN_W = 3,
  parameter int OUT_W = 3,
  parameter logic [IN_W-1:0] LFSR_POLY = 3'b110,
  parameter logic [IN_W-1:0] LFSR_SEED = 3'b001,
  parameter logic [OUT_W-1:0] MISR_POLY = 3'b110,
  parameter int NUM_PAT = 7,
  parameter int CUT_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [OUT_W-1:0] golden_i,
  input  logic [OUT_W-1:0] resp_i,
  output logic [IN_W-1:0]  pat_o,
  output logic             pat_vld_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [OUT_W-1:0] sig_o
);
  localparam int CW = cnt_w(NUM_PAT, CUT_LAT);
  localparam logic [CW-1:0] PAT_LAST = CW'(NUM_PAT - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'((CUT_LAT > 0) ? CUT_LAT - 1 : 0);
  state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic reload, cap, fin, res_vld;
  logic [OUT_W-1:0] gold_q;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    reload = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        state_nxt = start_i ? RUN : IDLE;
        reload = start_i;
      end
      RUN: begin
        cnt_nxt = (cnt == PAT_LAST) ? '0 : cnt + 1'b1;
        if (cnt == PAT_LAST) state_nxt = (CUT_LAT > 0) ? DRAIN : DONE;
      end
      DRAIN: begin
        cnt_nxt = (cnt == LAT_LAST) ? '0 : cnt + 1'b1;
        if (cnt == LAT_LAST) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  assign fin = (state_nxt == DONE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      res_vld <= 1'b0;
      gold_q <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      res_vld <= reload ? 1'b0 : (fin | res_vld);
      gold_q <= fin ? golden_i : gold_q;
    end
  assign pat_vld_o = (state == RUN);
  assign busy_o = (state == RUN) || (state == DRAIN);
  assign done_o = (state == DONE);
  // golden is latched on the final MISR update; both it and sig_o then hold until the next start
  assign pass_o = res_vld && (sig_o == gold_q);
  generate
    if (CUT_LAT == 0) begin : g_wire
      assign cap = pat_vld_o;
    end else begin : g_dly
      logic [CUT_LAT-1:0] dly;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dly <= '0;
        else dly <= (dly << 1) | CUT_LAT'(pat_vld_o);
      assign cap = dly[CUT_LAT-1];
    end
  endgenerate
  bist_shreg #(.W(IN_W), .POLY(LFSR_POLY), .INIT(LFSR_SEED)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (pat_vld_o),
    .load     (reload),
    .mode     (SR_AUTO),
    .load_val (LFSR_SEED),
    .din      ('0),
    .q        (pat_o)
  );
  bist_shreg #(.W(OUT_W), .POLY(MISR_POLY)) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (cap),
    .load     (reload),
    .mode     (SR_INJ),
    .load_val ('0),
    .din      (resp_i),
    .q        (sig_o)
  );
endmodule

// File: tb/tb_bist_ctrl.sv
// tb_bist_ctrl: directed runs on a zero-latency and a two-cycle-latency instance, checked against a run-level model.
module tb_bist_ctrl;
  localparam int N = 7;
  int lat [2] = '{0, 2};
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] golden;
  logic zero;
  logic start [2];
  logic [2:0] pat [2];
  logic [2:0] sig [2];
  logic vld [2], busy [2], done [2], pass [2];
  logic [2:0] resp0;
  logic [2:0] dly1 = '0, resp2 = '0;
  logic rs_s = 1'b0;
  logic st_s [2];
  logic [2:0] g_s;
  int total = 0, bad = 0;
  int t [2];
  bit ran [2], zr [2];
  logic [2:0] gold_m [2], fin [2], held_pat [2];
  logic [2:0] lit [7] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};

  bist_ctrl u_d0 (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .golden_i(golden), .resp_i(resp0),
    .pat_o(pat[0]), .pat_vld_o(vld[0]), .busy_o(busy[0]), .done_o(done[0]),
    .pass_o(pass[0]), .sig_o(sig[0])
  );
  bist_ctrl #(.CUT_LAT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .golden_i(golden), .resp_i(resp2),
    .pat_o(pat[1]), .pat_vld_o(vld[1]), .busy_o(busy[1]), .done_o(done[1]),
    .pass_o(pass[1]), .sig_o(sig[1])
  );

  always #5 clk = ~clk;
  assign resp0 = zero ? 3'b000 : pat[0];
  always @(posedge clk) begin
    dly1 <= pat[1];
    resp2 <= dly1;
    rs_s <= rst_n;
    st_s <= start;
    g_s <= golden;
  end

  function automatic logic [2:0] pat_at(input int k);
    logic [2:0] v = 3'b001;
    for (int i = 0; i < k; i++) v = {v[1:0], ^(v & 3'b110)};
    return v;
  endfunction
  function automatic logic [2:0] sig_after(input int c, input bit z);
    logic [2:0] s = 3'b000;
    for (int j = 0; j < c; j++) s = {s[1:0], ^(s & 3'b110)} ^ (z ? 3'b000 : pat_at(j));
    return s;
  endfunction
  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input int d);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
  endtask

  // model: t counts cycles since the accepted start (1 = first RUN cycle), 0 when idle
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int dn, c;
      dn = N + lat[d] + 1;
      if (!rst_n || !rs_s) begin
        t[d] = 0; ran[d] = 0; zr[d] = 0; fin[d] = '0; gold_m[d] = '0; held_pat[d] = 3'b001;
      end else if (t[d] == 0 || t[d] == dn) begin
        if (st_s[d]) begin
          t[d] = 1; ran[d] = 0; zr[d] = (d == 0) && zero;
        end else t[d] = 0;
      end else begin
        t[d]++;
        if (t[d] == dn) begin
          ran[d] = 1; gold_m[d] = g_s; fin[d] = sig_after(N, zr[d]); held_pat[d] = pat_at(N);
        end
      end
      c = t[d] - lat[d] - 1;
      if (c < 0) c = 0;
      chk($sformatf("d%0d.vld", d), 3'(vld[d]), 3'(t[d] >= 1 && t[d] <= N));
      chk($sformatf("d%0d.busy", d), 3'(busy[d]), 3'(t[d] >= 1 && t[d] <= N + lat[d]));
      chk($sformatf("d%0d.done", d), 3'(done[d]), 3'(t[d] == dn));
      chk($sformatf("d%0d.pat", d), pat[d],
          (t[d] >= 1 && t[d] <= N) ? pat_at(t[d] - 1) : (t[d] > N ? pat_at(N) : held_pat[d]));
      chk($sformatf("d%0d.sig", d), sig[d], (t[d] >= 1) ? sig_after(c, zr[d]) : fin[d]);
      chk($sformatf("d%0d.pass", d), 3'(pass[d]), 3'(ran[d] && fin[d] == gold_m[d]));
    end
  end

  initial begin
    int dr;
    rst_n = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    golden = 3'b100;
    zero = 1'b0;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst.pat", pat[d], 3'b001);
      chk("rst.sig", sig[d], 3'b000);
      chk("rst.busy", 3'(busy[d]), 3'b000);
      chk("rst.pass", 3'(pass[d]), 3'b000);
    end
    rst_n = 1'b1;
    tick();
    // nominal run, pattern sequence pinned by hand
    pulse(0);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("t1.pat%0d", k), pat[0], lit[k]);
      chk("t1.early_done", 3'(done[0]), 3'b000);
      tick();
    end
    chk("t1.done", 3'(done[0]), 3'b001);
    chk("t1.sig", sig[0], 3'b100);
    chk("t1.pass", 3'(pass[0]), 3'b001);
    tick();
    chk("t1.hold_sig", sig[0], 3'b100);
    chk("t1.hold_pass", 3'(pass[0]), 3'b001);
    // wrong golden
    golden = 3'b000;
    pulse(0);
    repeat (N) tick();
    chk("t2.done", 3'(done[0]), 3'b001);
    chk("t2.sig", sig[0], 3'b100);
    chk("t2.pass", 3'(pass[0]), 3'b000);
    tick();
    // all-zero responses
    zero = 1'b1;
    pulse(0);
    for (int k = 0; k < N; k++) begin
      chk("t3.sig_run", sig[0], 3'b000);
      tick();
    end
    chk("t3.sig", sig[0], 3'b000);
    chk("t3.pass", 3'(pass[0]), 3'b001);
    tick();
    zero = 1'b0;
    golden = 3'b100;
    // pipelined cut with two-cycle latency
    dr = 0;
    pulse(1);
    for (int i = 0; i < N + 2; i++) begin
      if (busy[1] && !vld[1]) dr++;
      tick();
    end
    chk("t4.done", 3'(done[1]), 3'b001);
    chk("t4.drain", 3'(dr), 3'd2);
    chk("t4.sig", sig[1], 3'b100);
    chk("t4.pass", 3'(pass[1]), 3'b001);
    tick();
    // start re-asserted mid-run is ignored
    pulse(0);
    tick();
    tick();
    start[0] = 1'b1;
    tick();
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    chk("t5.not_yet", 3'(done[0]), 3'b000);
    tick();
    chk("t5.done", 3'(done[0]), 3'b001);
    chk("t5.sig", sig[0], 3'b100);
    tick();
    chk("t5.idle", 3'(busy[0]), 3'b000);
    // start held through DONE restarts immediately
    start[0] = 1'b1;
    tick();
    repeat (N) tick();
    chk("t6.done", 3'(done[0]), 3'b001);
    chk("t6.pass", 3'(pass[0]), 3'b001);
    tick();
    chk("t6.rerun", 3'(busy[0]), 3'b001);
    chk("t6.seed", pat[0], 3'b001);
    chk("t6.pass_clr", 3'(pass[0]), 3'b000);
    chk("t6.sig_clr", sig[0], 3'b000);
    start[0] = 1'b0;
    repeat (N) tick();
    chk("t6.done2", 3'(done[0]), 3'b001);
    tick();
    // asynchronous reset in RUN cycle 3
    pulse(0);
    repeat (3) tick();
    chk("t7.pat3", pat[0], 3'b011);
    #2 rst_n = 1'b0;
    #1;
    chk("t7.pat", pat[0], 3'b001);
    chk("t7.vld", 3'(vld[0]), 3'b000);
    chk("t7.busy", 3'(busy[0]), 3'b000);
    chk("t7.done", 3'(done[0]), 3'b000);
    chk("t7.sig", sig[0], 3'b000);
    chk("t7.pass", 3'(pass[0]), 3'b000);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("t7.stay_idle", 3'(busy[0]), 3'b000);
    end
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
